// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT signed samples with saturation, then holds the
// result under a valid/ready handshake until the consumer takes it.
module sum_accum #(
    parameter int          WIDTH = 32,
    parameter int unsigned COUNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sum,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_ovf,
    output logic [7:0]       o_count
);

    localparam logic [7:0]       CountMax = 8'(COUNT);
    localparam logic [WIDTH-1:0] SatMax   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [7:0]       count_q;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] acc_next;
    logic             sat;
    logic [7:0]       count_inc;

    // Sign-extended add; the top two bits disagree exactly when the result overflows.
    always_comb begin
        sum_ext   = {acc_q[WIDTH-1], acc_q} + {i_sum[WIDTH-1], i_sum};
        sat       = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        acc_next  = sum_ext[WIDTH-1:0];
        if (sat) begin
            acc_next = sum_ext[WIDTH] ? SatMin : SatMax;
        end
        count_inc = count_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        acc_q   <= i_sum;
                        ovf_q   <= 1'b0;
                        count_q <= 8'd1;
                        state_q <= (CountMax == 8'd1) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (i_valid) begin
                        acc_q   <= acc_next;
                        ovf_q   <= ovf_q | sat;
                        count_q <= count_inc;
                        if (count_inc == CountMax) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Result stays on o_acc/o_ovf after the handshake; only the count clears.
                    if (i_ready) begin
                        state_q <= StIdle;
                        count_q <= 8'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready = ~i_rst & (state_q != StHold);
    assign o_valid = (state_q == StHold);
    assign o_acc   = acc_q;
    assign o_ovf   = ovf_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum (WIDTH=32, COUNT=4): frame sums, saturation,
// back-pressure, mid-frame reset and gapped input.
module tb_sum_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_sum;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_acc;
    logic        out_ovf;
    logic [7:0]  out_count;

    int n_cmp = 0;
    int n_err = 0;

    sum_accum #(
        .WIDTH(32),
        .COUNT(4)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_sum   (in_sum),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_acc   (out_acc),
        .o_ovf   (out_ovf),
        .o_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted sample: drive for a single edge, then drop valid.
    task automatic feed(input logic [31:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] acc, input logic ovf);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_acc"},   64'(out_acc),   64'(acc));
        chk({tag, "_ovf"},   64'(out_ovf),   64'(ovf));
        chk({tag, "_count"}, 64'(out_count), 64'd4);
        chk({tag, "_ready"}, 64'(out_ready), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sum   = 32'd77;
        in_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 64'(out_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_acc",   64'(out_acc),   64'd0);
        chk("rst_ovf",   64'(out_ovf),   64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_ready", 64'(out_ready), 64'd1);

        // Back-to-back 1,2,3,4 with consumer ready.
        feed(32'd1);
        chk("b2b_count1", 64'(out_count), 64'd1);
        feed(32'd2);
        feed(32'd3);
        chk("b2b_no_valid", 64'(out_valid), 64'd0);
        feed(32'd4);
        chk_frame("b2b", 32'd10, 1'b0);
        step();
        chk("b2b_done_valid", 64'(out_valid), 64'd0);
        chk("b2b_done_ready", 64'(out_ready), 64'd1);
        chk("b2b_done_count", 64'(out_count), 64'd0);
        chk("b2b_done_acc",   64'(out_acc),   64'd10);

        // Positive saturation, then a clean frame clears the sticky flag.
        feed(32'h7FFF_FFFF);
        feed(32'd1);
        chk("pos_sat_mid_acc", 64'(out_acc), 64'h7FFF_FFFF);
        chk("pos_sat_mid_ovf", 64'(out_ovf), 64'd1);
        feed(32'd0);
        feed(32'd0);
        chk_frame("pos_sat", 32'h7FFF_FFFF, 1'b1);
        step();
        chk("pos_sat_sticky", 64'(out_ovf), 64'd1);
        feed(32'd1);
        chk("new_frame_ovf_clr", 64'(out_ovf), 64'd0);
        feed(32'd1);
        feed(32'd1);
        feed(32'd1);
        chk_frame("ones", 32'd4, 1'b0);
        step();

        // Negative saturation: -2^31 + -1 clamps to -2^31, then +5 gives -2^31+5.
        feed(32'h8000_0000);
        feed(32'hFFFF_FFFF);
        chk("neg_sat_mid_acc", 64'(out_acc), 64'h8000_0000);
        feed(32'd5);
        feed(32'd0);
        chk_frame("neg_sat", 32'h8000_0005, 1'b1);
        step();

        // Back-pressure: result held, samples ignored until the handshake completes.
        in_ready = 1'b0;
        feed(32'd2);
        feed(32'd2);
        feed(32'd2);
        feed(32'd2);
        chk_frame("hold0", 32'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum   = 32'd99;
            step();
            chk_frame("hold_stall", 32'd8, 1'b0);
        end
        in_ready = 1'b1;
        step();
        chk("hold_rel_valid", 64'(out_valid), 64'd0);
        chk("hold_rel_count", 64'(out_count), 64'd0);
        chk("hold_rel_acc",   64'(out_acc),   64'd8);
        chk("hold_rel_ready", 64'(out_ready), 64'd1);
        step();
        chk("after_hold_accept", 64'(out_count), 64'd1);
        chk("after_hold_acc",    64'(out_acc),   64'd99);
        in_valid = 1'b0;

        // Reset mid-frame discards the partial sum.
        rst = 1'b1;
        in_valid = 1'b1;
        in_sum = 32'd9;
        step();
        chk("midrst_count", 64'(out_count), 64'd0);
        chk("midrst_acc",   64'(out_acc),   64'd0);
        chk("midrst_ready", 64'(out_ready), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        feed(32'd7);
        feed(32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", 64'(out_count), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            feed(32'd5);
            chk("rst_frame_no_valid", 64'(out_valid), 64'd0);
        end
        feed(32'd5);
        chk_frame("rst_frame", 32'd20, 1'b0);
        step();

        // Gapped samples: state frozen across idle cycles.
        in_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            feed(32'(k + 2));
            chk("gap_count", 64'(out_count), 64'(k));
            for (int g = 0; g < 2; g++) begin
                step();
                chk("gap_hold_count", 64'(out_count), 64'(k));
                chk("gap_valid", 64'(out_valid), (k == 4) ? 64'd1 : 64'd0);
            end
        end
        chk_frame("gap", 32'd18, 1'b0);
        in_ready = 1'b1;
        step();
        chk("gap_done_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
